bus: RTL and testbench

- Shared on-chip system bus connecting 4 masters to 8 slaves.
- Contains three parts:
  - a registered round-robin arbiter producing a one-hot grant;
  - a combinational master-to-slave multiplexer for address, strobe, rw and write data;
  - an address decoder producing one-hot slave chip selects, with a slave-to-master read-data/ready multiplexer.
- Sits between CPU/DMA-type masters and memory/peripheral slaves.

---
 rtl/bus_if.sv | 62 ++++++
 rtl/bus.sv | 115 +++++++++++
 tb/tb_bus.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_if.sv
// Signal bundle for the shared 4-master / 8-slave system bus.
// The master and slave modports give each agent's view, and fabric is the view of the bus itself.
interface bus_if #(
    parameter int WORD        = 32,
    parameter int WORD_ADDR_W = 30
);
    logic [3:0]             mreq;
    logic [3:0]             m_as;
    logic [3:0]             addrstr;
    logic [3:0]             rw;
    logic [WORD_ADDR_W-1:0] m0_addr;
    logic [WORD_ADDR_W-1:0] m1_addr;
    logic [WORD_ADDR_W-1:0] m2_addr;
    logic [WORD_ADDR_W-1:0] m3_addr;
    logic [WORD-1:0]        m0_rw_data;
    logic [WORD-1:0]        m1_rw_data;
    logic [WORD-1:0]        m2_rw_data;
    logic [WORD-1:0]        m3_rw_data;
    logic [WORD-1:0]        m_rd_data;
    logic                   m_rdy;
    logic [3:0]             grnt;

    logic [7:0]             rdy;
    logic [WORD-1:0]        s0_rd_data;
    logic [WORD-1:0]        s1_rd_data;
    logic [WORD-1:0]        s2_rd_data;
    logic [WORD-1:0]        s3_rd_data;
    logic [WORD-1:0]        s4_rd_data;
    logic [WORD-1:0]        s5_rd_data;
    logic [WORD-1:0]        s6_rd_data;
    logic [WORD-1:0]        s7_rd_data;
    logic [7:0]             s_chip;
    logic [WORD_ADDR_W-1:0] s_addr;
    logic                   s_as;
    logic                   s_rw;
    logic [WORD-1:0]        s_wr_data;

    modport master (
        output mreq, m_as, addrstr, rw,
        output m0_addr, m1_addr, m2_addr, m3_addr,
        output m0_rw_data, m1_rw_data, m2_rw_data, m3_rw_data,
        input  m_rd_data, m_rdy, grnt
    );

    modport slave (
        input  s_chip, s_addr, s_as, s_rw, s_wr_data,
        output rdy,
        output s0_rd_data, s1_rd_data, s2_rd_data, s3_rd_data,
        output s4_rd_data, s5_rd_data, s6_rd_data, s7_rd_data
    );

    modport fabric (
        input  mreq, m_as, addrstr, rw,
        input  m0_addr, m1_addr, m2_addr, m3_addr,
        input  m0_rw_data, m1_rw_data, m2_rw_data, m3_rw_data,
        output m_rd_data, m_rdy, grnt,
        output s_chip, s_addr, s_as, s_rw, s_wr_data,
        input  rdy,
        input  s0_rd_data, s1_rd_data, s2_rd_data, s3_rd_data,
        input  s4_rd_data, s5_rd_data, s6_rd_data, s7_rd_data
    );
endinterface

// File: rtl/bus.sv
// Shared system bus: registered round-robin arbiter, master-to-slave mux,
// top-3-bit address decoder and slave-to-master read mux.
module bus #(
    parameter int WORD        = 32,
    parameter int WORD_ADDR_W = 30
) (
    input logic   Clk,
    input logic   Reset,
    bus_if.fabric b
);
    logic [3:0]             grnt_q;
    logic [3:0]             grnt_d;
    logic [1:0]             ptr_q;
    logic [1:0]             ptr_d;
    logic [1:0]             owner;
    logic                   owner_valid;
    logic [1:0]             cand;
    logic                   found;

    logic [WORD_ADDR_W-1:0] sel_addr;
    logic [WORD-1:0]        sel_wr_data;
    logic [2:0]             slave_idx;
    logic [WORD-1:0]        sel_rd_data;

    assign owner_valid = |grnt_q;

    always_comb begin
        owner = 2'd0;
        case (grnt_q)
            4'b0010: owner = 2'd1;
            4'b0100: owner = 2'd2;
            4'b1000: owner = 2'd3;
            default: owner = 2'd0;
        endcase
    end

    // The owner keeps the bus while it requests or locks; otherwise the search
    // starts just after the last owner, so release and re-grant share one edge.
    always_comb begin
        grnt_d = grnt_q;
        ptr_d  = ptr_q;
        found  = 1'b0;
        cand   = 2'd0;
        if (!(owner_valid && (b.mreq[owner] || b.addrstr[owner]))) begin
            grnt_d = 4'b0000;
            for (int i = 1; i <= 4; i++) begin
                cand = ptr_q + 2'(i);
                if (!found && b.mreq[cand]) begin
                    found  = 1'b1;
                    grnt_d = 4'b0001 << cand;
                    ptr_d  = cand;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            grnt_q <= 4'b0000;
            ptr_q  <= 2'd3;
        end else begin
            grnt_q <= grnt_d;
            ptr_q  <= ptr_d;
        end
    end

    always_comb begin
        sel_addr    = b.m0_addr;
        sel_wr_data = b.m0_rw_data;
        case (owner)
            2'd1: begin
                sel_addr    = b.m1_addr;
                sel_wr_data = b.m1_rw_data;
            end
            2'd2: begin
                sel_addr    = b.m2_addr;
                sel_wr_data = b.m2_rw_data;
            end
            2'd3: begin
                sel_addr    = b.m3_addr;
                sel_wr_data = b.m3_rw_data;
            end
            default: begin
                sel_addr    = b.m0_addr;
                sel_wr_data = b.m0_rw_data;
            end
        endcase
    end

    assign b.grnt      = grnt_q;
    assign b.s_addr    = owner_valid ? sel_addr : '0;
    assign b.s_wr_data = owner_valid ? sel_wr_data : '0;
    assign b.s_rw      = owner_valid & b.rw[owner];
    assign b.s_as      = owner_valid & b.m_as[owner];

    assign slave_idx   = b.s_addr[WORD_ADDR_W-1 -: 3];
    assign b.s_chip    = {7'b0, b.s_as} << slave_idx;

    always_comb begin
        sel_rd_data = b.s0_rd_data;
        case (slave_idx)
            3'd1:    sel_rd_data = b.s1_rd_data;
            3'd2:    sel_rd_data = b.s2_rd_data;
            3'd3:    sel_rd_data = b.s3_rd_data;
            3'd4:    sel_rd_data = b.s4_rd_data;
            3'd5:    sel_rd_data = b.s5_rd_data;
            3'd6:    sel_rd_data = b.s6_rd_data;
            3'd7:    sel_rd_data = b.s7_rd_data;
            default: sel_rd_data = b.s0_rd_data;
        endcase
    end

    assign b.m_rd_data = b.s_as ? sel_rd_data : '0;
    assign b.m_rdy     = b.s_as & b.rdy[slave_idx];
endmodule

// File: tb/tb_bus.sv
// Testbench for bus: directed vectors with literal expectations, plus a
// per-cycle comparison against a behavioural model of arbitration and routing.
module tb_bus;
    localparam int WORD        = 32;
    localparam int WORD_ADDR_W = 30;

    logic                   Clk;
    logic                   Reset;
    logic [3:0]             mreq;
    logic [3:0]             m_as;
    logic [3:0]             addrstr;
    logic [3:0]             rw;
    logic [7:0]             rdy;
    logic [WORD_ADDR_W-1:0] m_addr [4];
    logic [WORD-1:0]        m_data [4];
    logic [WORD-1:0]        s_data [8];

    int errors = 0;
    int checks = 0;

    int model_owner = -1;
    int model_last  = 3;

    bus_if #(.WORD(WORD), .WORD_ADDR_W(WORD_ADDR_W)) bus_port ();

    assign bus_port.mreq       = mreq;
    assign bus_port.m_as       = m_as;
    assign bus_port.addrstr    = addrstr;
    assign bus_port.rw         = rw;
    assign bus_port.rdy        = rdy;
    assign bus_port.m0_addr    = m_addr[0];
    assign bus_port.m1_addr    = m_addr[1];
    assign bus_port.m2_addr    = m_addr[2];
    assign bus_port.m3_addr    = m_addr[3];
    assign bus_port.m0_rw_data = m_data[0];
    assign bus_port.m1_rw_data = m_data[1];
    assign bus_port.m2_rw_data = m_data[2];
    assign bus_port.m3_rw_data = m_data[3];
    assign bus_port.s0_rd_data = s_data[0];
    assign bus_port.s1_rd_data = s_data[1];
    assign bus_port.s2_rd_data = s_data[2];
    assign bus_port.s3_rd_data = s_data[3];
    assign bus_port.s4_rd_data = s_data[4];
    assign bus_port.s5_rd_data = s_data[5];
    assign bus_port.s6_rd_data = s_data[6];
    assign bus_port.s7_rd_data = s_data[7];

    bus #(.WORD(WORD), .WORD_ADDR_W(WORD_ADDR_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .b     (bus_port.fabric)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] as_v,
                                 input logic [3:0] lock, input logic [3:0] dir);
        mreq    = req;
        m_as    = as_v;
        addrstr = lock;
        rw      = dir;
    endtask

    task automatic nextEdge();
        @(posedge Clk);
        #1;
    endtask

    // Model: owner held while it requests or locks, else first requester after the last owner
    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            model_owner = -1;
            model_last  = 3;
        end else if (!(model_owner >= 0 && (mreq[model_owner] || addrstr[model_owner]))) begin
            model_owner = -1;
            for (int k = 1; k <= 4; k++) begin
                if (model_owner < 0 && mreq[(model_last + k) % 4]) model_owner = (model_last + k) % 4;
            end
            if (model_owner >= 0) model_last = model_owner;
        end
    end

    // Every cycle the routed outputs follow from the model owner and current inputs
    always @(negedge Clk) begin
        logic [3:0]             exp_grnt;
        logic [WORD_ADDR_W-1:0] exp_addr;
        logic [WORD-1:0]        exp_wr;
        logic [WORD-1:0]        exp_rd;
        logic                   exp_as;
        logic                   exp_rw;
        logic                   exp_rdy;
        logic [7:0]             exp_chip;
        int                     region;
        exp_grnt = 4'b0000;
        exp_addr = '0;
        exp_wr   = '0;
        exp_as   = 1'b0;
        exp_rw   = 1'b0;
        if (model_owner >= 0) begin
            exp_grnt = 4'(1 << model_owner);
            exp_addr = m_addr[model_owner];
            exp_wr   = m_data[model_owner];
            exp_as   = m_as[model_owner];
            exp_rw   = rw[model_owner];
        end
        region   = int'(exp_addr / (2 ** (WORD_ADDR_W - 3)));
        exp_chip = exp_as ? 8'(1 << region) : 8'h00;
        exp_rd   = exp_as ? s_data[region] : '0;
        exp_rdy  = exp_as ? rdy[region] : 1'b0;
        checkOutput("model grnt", 32'(bus_port.grnt), 32'(exp_grnt));
        checkOutput("model s_addr", 32'(bus_port.s_addr), 32'(exp_addr));
        checkOutput("model s_wr_data", bus_port.s_wr_data, exp_wr);
        checkOutput("model s_as", 32'(bus_port.s_as), 32'(exp_as));
        checkOutput("model s_rw", 32'(bus_port.s_rw), 32'(exp_rw));
        checkOutput("model s_chip", 32'(bus_port.s_chip), 32'(exp_chip));
        checkOutput("model m_rd_data", bus_port.m_rd_data, exp_rd);
        checkOutput("model m_rdy", 32'(bus_port.m_rdy), 32'(exp_rdy));
    end

    initial begin
        logic [3:0]  rr_exp [4];
        logic [31:0] wide_addr;
        rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        for (int j = 0; j < 8; j++) s_data[j] = 32'h1000_0000 + 32'(j);
        rdy = 8'h00;

        // Reset with every master requesting
        Reset = 1'b1;
        applyStimulus(4'hF, 4'hF, 4'h0, 4'h0);
        #2;
        checkOutput("reset grnt", 32'(bus_port.grnt), 32'h0);
        checkOutput("reset s_chip", 32'(bus_port.s_chip), 32'h0);
        checkOutput("reset s_as", 32'(bus_port.s_as), 32'h0);
        checkOutput("reset m_rdy", 32'(bus_port.m_rdy), 32'h0);
        applyStimulus(4'h0, 4'h0, 4'h0, 4'h0);
        nextEdge();
        nextEdge();
        Reset = 1'b0;
        nextEdge();

        // Single write request from master 2
        m_addr[2] = 30'h3FFF0002;
        m_data[2] = 32'h2;
        applyStimulus(4'b0100, 4'b0100, 4'h0, 4'h0);
        nextEdge();
        checkOutput("single grnt", 32'(bus_port.grnt), 32'h4);
        checkOutput("single s_addr", 32'(bus_port.s_addr), 32'h3FFF0002);
        checkOutput("single s_wr_data", bus_port.s_wr_data, 32'h2);
        checkOutput("single s_rw", 32'(bus_port.s_rw), 32'h0);
        checkOutput("single s_chip", 32'(bus_port.s_chip), 32'h80);

        // Idle after ownership
        applyStimulus(4'h0, 4'b0100, 4'h0, 4'h0);
        nextEdge();
        checkOutput("idle grnt", 32'(bus_port.grnt), 32'h0);
        checkOutput("idle s_as", 32'(bus_port.s_as), 32'h0);
        checkOutput("idle s_chip", 32'(bus_port.s_chip), 32'h0);
        checkOutput("idle m_rd_data", bus_port.m_rd_data, 32'h0);

        // Fresh pointer, then round-robin under continuous requests
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
        nextEdge();
        checkOutput("rr first grnt", 32'(bus_port.grnt), 32'h1);
        nextEdge();
        nextEdge();
        checkOutput("rr hold grnt", 32'(bus_port.grnt), 32'h1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'hF & ~(4'b0001 << k), 4'h0, 4'h0, 4'h0);
            nextEdge();
            checkOutput("rr release grnt", 32'(bus_port.grnt), 32'(rr_exp[k]));
            applyStimulus(4'hF, 4'h0, 4'h0, 4'h0);
            nextEdge();
            checkOutput("rr rehold grnt", 32'(bus_port.grnt), 32'(rr_exp[k]));
        end

        // Read path through master 1 to slave 1
        m_addr[1] = 30'h08000000;
        s_data[1] = 32'hFFFFFFFE;
        rdy       = 8'h02;
        applyStimulus(4'b0010, 4'b0010, 4'h0, 4'b0010);
        nextEdge();
        checkOutput("read grnt", 32'(bus_port.grnt), 32'h2);
        checkOutput("read s_chip", 32'(bus_port.s_chip), 32'h02);
        checkOutput("read m_rd_data", bus_port.m_rd_data, 32'hFFFFFFFE);
        checkOutput("read m_rdy", 32'(bus_port.m_rdy), 32'h1);
        checkOutput("read s_rw", 32'(bus_port.s_rw), 32'h1);
        rdy = 8'h01;
        #1;
        checkOutput("read wait m_rdy", 32'(bus_port.m_rdy), 32'h0);

        // Bus lock held by master 3
        applyStimulus(4'b1000, 4'b1000, 4'h0, 4'h0);
        nextEdge();
        checkOutput("lock owner grnt", 32'(bus_port.grnt), 32'h8);
        applyStimulus(4'b0001, 4'b1000, 4'b1000, 4'h0);
        nextEdge();
        checkOutput("lock hold grnt", 32'(bus_port.grnt), 32'h8);
        nextEdge();
        checkOutput("lock hold2 grnt", 32'(bus_port.grnt), 32'h8);
        applyStimulus(4'b0001, 4'b0001, 4'h0, 4'h0);
        nextEdge();
        checkOutput("unlock grnt", 32'(bus_port.grnt), 32'h1);

        // Wide address truncated to the word-address width
        wide_addr = 32'hFFFF0003;
        m_addr[0] = wide_addr[WORD_ADDR_W-1:0];
        s_data[7] = 32'hA5A5_0007;
        rdy       = 8'h00;
        #1;
        checkOutput("trunc s_addr", 32'(bus_port.s_addr), 32'h3FFF0003);
        checkOutput("trunc s_chip", 32'(bus_port.s_chip), 32'h80);
        checkOutput("trunc wait m_rdy", 32'(bus_port.m_rdy), 32'h0);
        nextEdge();
        rdy = 8'h80;
        #1;
        checkOutput("trunc m_rdy", 32'(bus_port.m_rdy), 32'h1);
        checkOutput("trunc m_rd_data", bus_port.m_rd_data, 32'hA5A5_0007);

        // Reset asserted mid-transaction clears the grant without a clock edge
        applyStimulus(4'b0100, 4'b0100, 4'h0, 4'h0);
        nextEdge();
        checkOutput("pre-reset grnt", 32'(bus_port.grnt), 32'h4);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async reset grnt", 32'(bus_port.grnt), 32'h0);
        checkOutput("async reset s_as", 32'(bus_port.s_as), 32'h0);
        nextEdge();
        nextEdge();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
